// File: rtl/spm_share_if.sv
// Bus bundle for the shared 8x8 multiplier controller.
// Carries the requester, response and engine channels plus busy.
interface spm_share_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [2*W-1:0]    rsp_product;
   logic              rsp_err;
   logic              mul_start;
   logic [W-1:0]      mul_multiplicand;
   logic [W-1:0]      mul_multiplier;
   logic [2*W-1:0]    mul_product;
   logic              mul_done;
   logic              busy;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      input  mul_product, mul_done,
      output req_ready, rsp_valid, rsp_id,
      output rsp_product, rsp_err, mul_start,
      output mul_multiplicand, mul_multiplier, busy
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      output mul_product, mul_done,
      input  req_ready, rsp_valid, rsp_id,
      input  rsp_product, rsp_err, mul_start,
      input  mul_multiplicand, mul_multiplier, busy
   );
endinterface

// File: rtl/spm_share_ctrl.sv
// Round-robin sharing of one serial-parallel multiplier engine.
// Optional mul_done watchdog enabled by defining SPM_SHARE_WDOG_EN.
module spm_share_ctrl #(
   parameter int NREQ        = 4,
   parameter int W           = 8,
   parameter int WDOG_CYCLES = 16
) (
   input logic        clk,
   input logic        rst,
   spm_share_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_RESP
   } state_t;

   state_t         r_state, w_next;
   logic [IDW-1:0] r_rr, r_id, w_gnt;
   logic           w_gnt_vld;
   logic [W-1:0]   r_a, r_b, w_a, w_b;
   logic           r_rsp_valid, r_rsp_err;
   logic [2*W-1:0] r_rsp_prod;
   logic           w_accept, w_done, w_tout;

   // search above the last grant first, then wrap to 0..r_rr
   always_comb begin : arb
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_gnt_vld && bus.req_valid[i] &&
             IDW'(i) > r_rr) begin
            w_gnt_vld = 1'b1;
            w_gnt     = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_gnt_vld && bus.req_valid[i] &&
             IDW'(i) <= r_rr) begin
            w_gnt_vld = 1'b1;
            w_gnt     = IDW'(i);
         end
      end
   end

   always_comb begin : opmux
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt == IDW'(i)) begin
            w_a = bus.req_a[i*W +: W];
            w_b = bus.req_b[i*W +: W];
         end
      end
   end

   assign w_accept = (r_state == S_IDLE) & w_gnt_vld;
   assign w_done   = (r_state == S_WAIT) & bus.mul_done;

`ifdef SPM_SHARE_WDOG_EN
   localparam int WDW = $clog2(WDOG_CYCLES + 1);
   logic [WDW-1:0] r_wdog;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wdog <= '0;
      else if (r_state != S_WAIT)
         r_wdog <= '0;
      else
         r_wdog <= r_wdog + 1'b1;
   end

   assign w_tout = (r_state == S_WAIT) & ~bus.mul_done &
                   (r_wdog == WDW'(WDOG_CYCLES - 1));
`else
   assign w_tout = 1'b0;
`endif

   // mul_done is not looked at in ISSUE: it may be stale
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_gnt_vld) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_done || w_tout) w_next = S_RESP;
         S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rr        <= IDW'(NREQ - 1);
         r_id        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_prod  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a  <= w_a;
            r_b  <= w_b;
            r_id <= w_gnt;
            r_rr <= w_gnt;
         end
         if (w_done || w_tout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_tout;
            r_rsp_prod  <= w_tout ? '0 : bus.mul_product;
         end else if (r_state == S_RESP && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign bus.req_ready = (w_accept && !rst) ?
                          (NREQ'(1) << w_gnt) : '0;
   assign bus.mul_start        = (r_state == S_ISSUE);
   assign bus.mul_multiplicand = r_a;
   assign bus.mul_multiplier   = r_b;
   assign bus.rsp_valid        = r_rsp_valid;
   assign bus.rsp_id           = r_id;
   assign bus.rsp_product      = r_rsp_prod;
   assign bus.rsp_err          = r_rsp_err;
   assign bus.busy             = (r_state != S_IDLE);
endmodule

// File: tb/tb_spm_share_ctrl.sv
// Bench for spm_share_ctrl: stub 8-cycle engine, queued requesters,
// per-cycle reference model plus hand-computed directed expectations.
module tb_spm_share_ctrl;
   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int WDOG = 16;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   spm_share_if #(.NREQ(NREQ), .W(W)) ifc ();

   spm_share_ctrl #(
      .NREQ(NREQ), .W(W), .WDOG_CYCLES(WDOG)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input longint act,
                        input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // engine stub: done rises 8 cycles after the start cycle ends
   logic         eng_stuck = 1'b0;
   int           e_cnt;
   logic [W-1:0] e_a, e_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ifc.mul_done    <= 1'b0;
         ifc.mul_product <= '0;
         e_cnt <= 0;
         e_a   <= '0;
         e_b   <= '0;
      end else if (ifc.mul_start) begin
         ifc.mul_done <= 1'b0;
         e_cnt <= eng_stuck ? 0 : 8;
         e_a   <= ifc.mul_multiplicand;
         e_b   <= ifc.mul_multiplier;
      end else if (e_cnt != 0) begin
         e_cnt <= e_cnt - 1;
         if (e_cnt == 1) begin
            ifc.mul_done    <= 1'b1;
            ifc.mul_product <= (2*W)'(e_a) * (2*W)'(e_b);
         end
      end
   end

   // requesters: each presents the head of its queue until accepted
   logic [W-1:0]      qa [NREQ][$];
   logic [W-1:0]      qb [NREQ][$];
   logic [NREQ-1:0]   hs = '0;
   logic [NREQ-1:0]   va;
   logic [NREQ*W-1:0] pa, pb;

   initial begin
      ifc.req_valid = '0;
      ifc.req_a     = '0;
      ifc.req_b     = '0;
      forever begin
         @(posedge clk);
         #1;
         va = '0;
         pa = '0;
         pb = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (((hs >> i) & 1) != 0 && qa[i].size() > 0) begin
               qa[i].delete(0);
               qb[i].delete(0);
            end
            if (qa[i].size() > 0) begin
               va |= NREQ'(1) << i;
               pa |= (NREQ*W)'(qa[i][0]) << (i*W);
               pb |= (NREQ*W)'(qb[i][0]) << (i*W);
            end
         end
         ifc.req_valid = va;
         ifc.req_a     = pa;
         ifc.req_b     = pb;
      end
   end

   // reference model: one operation in flight, timed from its handshake
   bit              m_busy = 0;
   int              m_rr   = NREQ - 1;
   int              m_cyc  = 0;
   int              m_id   = 0;
   longint          m_p    = 0;
   bit              m_err  = 0;
   int              m_lat  = 11;
   int              g, j;
   bit              vexp;
   logic [NREQ-1:0] exp_rdy;
   logic [W-1:0]    ma, mb;
   bit              prev_hold = 0;
   longint          pv_id, pv_p, pv_err;
   int              log_id[$], log_lat[$], log_cyc[$];
   longint          log_p[$];
   bit              log_err[$];

   always @(negedge clk) begin
      cyc++;
      hs = '0;
      if (rst) begin
         m_busy    = 0;
         m_rr      = NREQ - 1;
         prev_hold = 0;
         check("rst_zero",
               longint'(ifc.req_ready != 0 || ifc.rsp_valid ||
                        ifc.busy || ifc.mul_start || ifc.rsp_err ||
                        ifc.mul_multiplicand != 0 ||
                        ifc.mul_multiplier != 0 ||
                        ifc.rsp_product != 0 || ifc.rsp_id != 0), 0);
      end else begin
         if (m_busy) m_cyc++;
         g = -1;
         if (!m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
               j = (m_rr + k) % NREQ;
               if (g < 0 && ((ifc.req_valid >> j) & 1) != 0) g = j;
            end
         end
         exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
         check("req_ready", ifc.req_ready, exp_rdy);
         check("busy", ifc.busy, m_busy);
         check("mul_start", ifc.mul_start, m_busy && m_cyc == 1);
         vexp = m_busy && m_cyc >= m_lat;
         check("rsp_valid", ifc.rsp_valid, vexp);
         if (vexp) begin
            check("rsp_id", ifc.rsp_id, m_id);
            check("rsp_product", ifc.rsp_product, m_p);
            check("rsp_err", ifc.rsp_err, m_err);
         end
         if (prev_hold) begin
            check("hold_id", ifc.rsp_id, pv_id);
            check("hold_product", ifc.rsp_product, pv_p);
            check("hold_err", ifc.rsp_err, pv_err);
         end
         prev_hold = ifc.rsp_valid && !ifc.rsp_ready;
         pv_id     = ifc.rsp_id;
         pv_p      = ifc.rsp_product;
         pv_err    = ifc.rsp_err;
         hs = ifc.req_valid & ifc.req_ready;
         if (vexp && ifc.rsp_ready) begin
            log_id.push_back(m_id);
            log_p.push_back(m_p);
            log_err.push_back(m_err);
            log_lat.push_back(m_cyc);
            log_cyc.push_back(cyc);
            m_busy = 0;
         end else if (g >= 0) begin
            ma     = W'(ifc.req_a >> (g*W));
            mb     = W'(ifc.req_b >> (g*W));
            m_busy = 1;
            m_cyc  = 0;
            m_rr   = g;
            m_id   = g;
            m_p    = eng_stuck ? 0 : longint'(ma) * longint'(mb);
            m_err  = eng_stuck;
            m_lat  = eng_stuck ? 2 + WDOG : 11;
         end
      end
   end

   task automatic push(input int r, input int a, input int b);
      qa[r].push_back(W'(a));
      qb[r].push_back(W'(b));
   endtask

   task automatic log_clear();
      log_id.delete();
      log_p.delete();
      log_err.delete();
      log_lat.delete();
      log_cyc.delete();
   endtask

   task automatic wait_log(input int n, input string nm,
                           output bit ok);
      int t;
      t = 0;
      while (log_id.size() < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      ok = (log_id.size() >= n);
      check({nm, "_count"}, log_id.size(), n);
   endtask

   bit ok;
   int t;
   int f_id[5] = '{0, 1, 2, 3, 0};
   int f_p[5]  = '{6, 20, 156, 750, 99};
   int x_p[3]  = '{65025, 0, 256};

   initial begin
      rst = 1'b1;
      ifc.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("init_rsp_valid", ifc.rsp_valid, 0);
      check("init_busy", ifc.busy, 0);
      check("init_mul_a", ifc.mul_multiplicand, 0);
      #2 rst = 1'b0;

      // fairness: all four requesting, requester 0 twice
      log_clear();
      push(0, 2, 3);
      push(0, 9, 11);
      push(1, 4, 5);
      push(2, 12, 13);
      push(3, 250, 3);
      wait_log(5, "fair", ok);
      if (ok) begin
         for (int k = 0; k < 5; k++) begin
            check("fair_id", log_id[k], f_id[k]);
            check("fair_prod", log_p[k], f_p[k]);
         end
         for (int k = 0; k < 4; k++)
            check("fair_period", log_cyc[k+1] - log_cyc[k], 12);
      end

      // single request with latency
      log_clear();
      push(1, 3, 5);
      wait_log(1, "single", ok);
      if (ok) begin
         check("single_id", log_id[0], 1);
         check("single_prod", log_p[0], 15);
         check("single_err", log_err[0], 0);
         check("single_lat", log_lat[0], 11);
      end

      // operand extremes
      log_clear();
      push(2, 255, 255);
      push(2, 0, 200);
      push(2, 128, 2);
      wait_log(3, "ext", ok);
      if (ok) begin
         for (int k = 0; k < 3; k++) begin
            check("ext_id", log_id[k], 2);
            check("ext_prod", log_p[k], x_p[k]);
         end
      end

      // response backpressure
      log_clear();
      ifc.rsp_ready = 1'b0;
      push(3, 10, 20);
      push(0, 6, 7);
      t = 0;
      while (!ifc.rsp_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid_seen", ifc.rsp_valid, 1);
      repeat (5) begin
         @(negedge clk);
         check("bp_busy", ifc.busy, 1);
         check("bp_req_ready", ifc.req_ready, 0);
         check("bp_id", ifc.rsp_id, 3);
         check("bp_prod", ifc.rsp_product, 200);
      end
      @(posedge clk);
      #1 ifc.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_next_grant", ifc.req_ready, 1);
      wait_log(2, "bp", ok);
      if (ok) begin
         check("bp_id0", log_id[0], 3);
         check("bp_prod0", log_p[0], 200);
         check("bp_id1", log_id[1], 0);
         check("bp_prod1", log_p[1], 42);
      end

      // reset while waiting on the engine
      log_clear();
      push(1, 50, 60);
      t = 0;
      while (!ifc.mul_start && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("rw_start_seen", ifc.mul_start, 1);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rw_busy", ifc.busy, 0);
      check("rw_mul_a", ifc.mul_multiplicand, 0);
      check("rw_mul_b", ifc.mul_multiplier, 0);
      check("rw_prod", ifc.rsp_product, 0);
      check("rw_id", ifc.rsp_id, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      push(2, 7, 9);
      wait_log(1, "rw", ok);
      if (ok) begin
         check("rw_new_id", log_id[0], 2);
         check("rw_new_prod", log_p[0], 63);
         check("rw_new_lat", log_lat[0], 11);
      end

`ifdef SPM_SHARE_WDOG_EN
      // engine never finishes
      log_clear();
      eng_stuck = 1'b1;
      push(0, 1, 2);
      wait_log(1, "wdog", ok);
      if (ok) begin
         check("wdog_id", log_id[0], 0);
         check("wdog_err", log_err[0], 1);
         check("wdog_prod", log_p[0], 0);
         check("wdog_lat", log_lat[0], 18);
      end
      eng_stuck = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
